// File: rtl/l1_write_buffer.sv
// Write-back buffer between the L1 data cache and DRAM: queues evicted lines,
// forwards them to read misses, coalesces repeat writes and drains to DRAM when it is idle.
module l1_write_buffer #(
    parameter int DEPTH       = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 256,
    parameter int OFFSET_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cache_addr_i,
    input  logic [DATA_WIDTH-1:0] cache_data_i,
    input  logic                  cache_cs_i,
    input  logic                  cache_we_i,
    output logic [DATA_WIDTH-1:0] cache_data_o,
    output logic                  cache_ack_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  mem_cs_o,
    output logic                  mem_we_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_ack_i,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int TAG_WIDTH = ADDR_WIDTH - OFFSET_BITS;
    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FILL, RESP, DRAIN} state_t;

    state_t                state;
    logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [PTR_WIDTH-1:0]  head;
    logic [PTR_WIDTH-1:0]  tail;
    logic [CNT_WIDTH-1:0]  count;
    logic                  rd_pend;
    logic [ADDR_WIDTH-1:0] rd_addr_q;

    logic [TAG_WIDTH-1:0]  req_tag;
    logic                  req;
    logic                  head_locked;
    logic                  full_now;
    logic                  wr_hit;
    logic                  rd_hit;
    logic [PTR_WIDTH-1:0]  wr_idx;
    logic [PTR_WIDTH-1:0]  rd_idx;
    logic [PTR_WIDTH-1:0]  idx;
    logic                  push;
    logic                  pop;
    logic                  wr_accept;
    logic [CNT_WIDTH-1:0]  count_next;

    // The head is locked against coalescing while it drains or is about to start draining this edge.
    always_comb begin
        req_tag     = cache_addr_i[ADDR_WIDTH-1:OFFSET_BITS];
        req         = cache_cs_i && !cache_ack_o && !rd_pend;
        head_locked = (state == DRAIN) || ((state == IDLE) && !rd_pend && (count != '0));
        wr_hit      = 1'b0;
        wr_idx      = '0;
        rd_hit      = 1'b0;
        rd_idx      = '0;
        idx         = '0;
        // Walk oldest to youngest so the last match is the youngest copy of a line.
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_WIDTH'(i);
            if (valid_q[idx] && (tag_q[idx] == req_tag)) begin
                rd_hit = 1'b1;
                rd_idx = idx;
                if (!(head_locked && (idx == head))) begin
                    wr_hit = 1'b1;
                    wr_idx = idx;
                end
            end
        end
        full_now   = (count == CNT_WIDTH'(DEPTH));
        push       = req && cache_we_i && !wr_hit && !full_now;
        wr_accept  = req && cache_we_i && (wr_hit || !full_now);
        pop        = (state == DRAIN) && mem_ack_i;
        count_next = count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            valid_q      <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            rd_pend      <= 1'b0;
            rd_addr_q    <= '0;
            cache_data_o <= '0;
            cache_ack_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            mem_cs_o     <= 1'b0;
            mem_we_o     <= 1'b0;
            full_o       <= 1'b0;
            empty_o      <= 1'b1;
        end else begin
            cache_ack_o <= 1'b0;
            if (wr_accept) begin
                cache_ack_o <= 1'b1;
                if (wr_hit) begin
                    data_q[wr_idx] <= cache_data_i;
                end else begin
                    tag_q[tail]   <= req_tag;
                    data_q[tail]  <= cache_data_i;
                    valid_q[tail] <= 1'b1;
                    tail          <= tail + 1'b1;
                end
            end
            if (req && !cache_we_i) begin
                if (rd_hit) begin
                    cache_data_o <= data_q[rd_idx];
                    cache_ack_o  <= 1'b1;
                end else begin
                    rd_pend   <= 1'b1;
                    rd_addr_q <= cache_addr_i;
                end
            end
            if (pop) begin
                valid_q[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            count   <= count_next;
            full_o  <= (count_next == CNT_WIDTH'(DEPTH));
            empty_o <= (count_next == '0);

            // A pending read miss always wins the next DRAM slot over further drains.
            case (state)
                IDLE: begin
                    if (rd_pend) begin
                        mem_addr_o <= rd_addr_q;
                        mem_we_o   <= 1'b0;
                        mem_cs_o   <= 1'b1;
                        state      <= FILL;
                    end else if (count != '0) begin
                        mem_addr_o <= {tag_q[head], {OFFSET_BITS{1'b0}}};
                        mem_data_o <= data_q[head];
                        mem_we_o   <= 1'b1;
                        mem_cs_o   <= 1'b1;
                        state      <= DRAIN;
                    end
                end
                FILL: begin
                    if (mem_ack_i) begin
                        mem_cs_o     <= 1'b0;
                        cache_data_o <= mem_data_i;
                        cache_ack_o  <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    rd_pend <= 1'b0;
                    state   <= IDLE;
                end
                DRAIN: begin
                    if (mem_ack_i) begin
                        mem_cs_o <= 1'b0;
                        mem_we_o <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l1_write_buffer.sv
// Bench for l1_write_buffer: a DRAM model with variable delay, a shadow image of the
// cache's view of memory, directed scenarios and a randomized read/write phase.
module tb_l1_write_buffer;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  cache_addr_i = '0;
    logic [255:0] cache_data_i = '0;
    logic         cache_cs_i = 1'b0;
    logic         cache_we_i = 1'b0;
    logic [255:0] cache_data_o;
    logic         cache_ack_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_cs_o;
    logic         mem_we_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;
    logic         full_o;
    logic         empty_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ack_cyc = 0;
    int dram_delay = 0;
    int wait_cnt = 0;

    logic [255:0] ext_mem [256];
    bit           ext_vld [256];
    logic [255:0] shadow  [256];
    logic         log_we   [$];
    logic [31:0]  log_addr [$];
    int           log_cyc  [$];

    l1_write_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .cache_addr_i (cache_addr_i),
        .cache_data_i (cache_data_i),
        .cache_cs_i   (cache_cs_i),
        .cache_we_i   (cache_we_i),
        .cache_data_o (cache_data_o),
        .cache_ack_o  (cache_ack_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_cs_o     (mem_cs_o),
        .mem_we_o     (mem_we_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i),
        .full_o       (full_o),
        .empty_o      (empty_o)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] init_line(input int i);
        return {8{32'hC0DE_0000 + 32'(i)}};
    endfunction

    function automatic logic [255:0] ext_line(input int i);
        return ext_vld[i] ? ext_mem[i] : init_line(i);
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // DRAM model: acks after dram_delay cycles of chip select, one-cycle ack pulse.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        mem_ack_i <= 1'b0;
        if (mem_cs_o === 1'b1 && !mem_ack_i) begin
            if (wait_cnt >= dram_delay) begin
                mem_ack_i <= 1'b1;
                wait_cnt  <= 0;
                log_we.push_back(mem_we_o);
                log_addr.push_back(mem_addr_o);
                log_cyc.push_back(cyc);
                if (mem_we_o) begin
                    ext_mem[mem_addr_o[12:5]] <= mem_data_o;
                    ext_vld[mem_addr_o[12:5]] <= 1'b1;
                end else begin
                    mem_data_i <= ext_line(int'(mem_addr_o[12:5]));
                end
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    // DRAM-side protocol: request held stable while selected, select dropped after ack.
    logic         prev_cs = 1'b0;
    logic         prev_ack = 1'b0;
    logic         prev_we = 1'b0;
    logic [31:0]  prev_addr = '0;
    logic [255:0] prev_data = '0;
    always @(negedge clk) begin
        if (prev_ack) begin
            check_val("dram_cs_drop", 256'(mem_cs_o), 256'(0));
        end else if (prev_cs && mem_cs_o === 1'b1) begin
            check_val("dram_addr_stable", 256'(mem_addr_o), 256'(prev_addr));
            check_val("dram_we_stable", 256'(mem_we_o), 256'(prev_we));
            if (prev_we) check_val("dram_data_stable", mem_data_o, prev_data);
        end
        prev_cs   = (mem_cs_o === 1'b1);
        prev_ack  = mem_ack_i;
        prev_we   = mem_we_o;
        prev_addr = mem_addr_o;
        prev_data = mem_data_o;
    end

    task automatic cache_req(input logic we, input logic [31:0] addr, input logic [255:0] data,
                             output int lat, output logic ok);
        @(negedge clk);
        for (int n = 0; n < 4 && cache_ack_o; n++) @(negedge clk);
        cache_cs_i   = 1'b1;
        cache_we_i   = we;
        cache_addr_i = addr;
        cache_data_i = data;
        ok  = 1'b0;
        lat = 0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(posedge clk);
            #1;
            lat++;
            if (cache_ack_o === 1'b1) ok = 1'b1;
        end
        cache_cs_i = 1'b0;
        cache_we_i = 1'b0;
        ack_cyc    = cyc;
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [255:0] data, input int exp_lat);
        int   lat;
        logic ok;
        cache_req(1'b1, addr, data, lat, ok);
        check_val({tag, "_acked"}, 256'(ok), 256'(1));
        if (exp_lat > 0) check_val({tag, "_lat"}, 256'(lat), 256'(exp_lat));
        shadow[addr[12:5]] = data;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input int exp_lat);
        int   lat;
        logic ok;
        cache_req(1'b0, addr, '0, lat, ok);
        check_val({tag, "_acked"}, 256'(ok), 256'(1));
        if (exp_lat > 0) check_val({tag, "_lat"}, 256'(lat), 256'(exp_lat));
        check_val({tag, "_data"}, cache_data_o, shadow[addr[12:5]]);
    endtask

    task automatic wait_idle(input string tag);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 2000 && !ok; n++) begin
            @(posedge clk);
            #1;
            if (empty_o === 1'b1 && mem_cs_o === 1'b0) ok = 1'b1;
        end
        check_val(tag, 256'(ok), 256'(1));
    endtask

    initial begin
        int           base;
        int           lat;
        int           cnt;
        logic         ok;
        logic [255:0] d;
        logic [31:0]  a;

        for (int i = 0; i < 256; i++) shadow[i] = init_line(i);

        // Reset held for two cycles.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_cache_ack", 256'(cache_ack_o), 256'(0));
        check_val("rst_cache_data", cache_data_o, 256'(0));
        check_val("rst_mem_cs", 256'(mem_cs_o), 256'(0));
        check_val("rst_mem_we", 256'(mem_we_o), 256'(0));
        check_val("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        check_val("rst_mem_data", mem_data_o, 256'(0));
        check_val("rst_full", 256'(full_o), 256'(0));
        check_val("rst_empty", 256'(empty_o), 256'(1));
        @(negedge clk);
        rst = 1'b0;

        // Single eviction drains to DRAM.
        dram_delay = 3;
        base = log_we.size();
        wr("w400", 32'h0000_0400, 256'hA5, 1);
        check_val("w400_not_empty", 256'(empty_o), 256'(0));
        wait_idle("w400_idle");
        check_val("w400_ext", ext_line(32), 256'hA5);
        check_val("w400_dram_addr", 256'(log_addr[base]), 256'(32'h400));
        check_val("w400_dram_we", 256'(log_we[base]), 256'(1));

        // Read forwarded from the buffer without touching DRAM.
        dram_delay = 10;
        base = log_we.size();
        wr("w40", 32'h0000_0040, 256'h77, 1);
        rd("fwd44", 32'h0000_0044, 1);
        wait_idle("fwd_idle");
        cnt = 0;
        for (int i = base; i < log_we.size(); i++) if (!log_we[i]) cnt++;
        check_val("fwd_no_dram_read", 256'(cnt), 256'(0));
        check_val("fwd_ext", ext_line(2), 256'h77);

        // Five distinct lines into four entries: the fifth stalls until the first pop.
        dram_delay = 20;
        base = log_we.size();
        for (int i = 0; i < 4; i++) wr("fill", 32'(i * 32), 256'h1000 + 256'(i), 1);
        check_val("fill_full", 256'(full_o), 256'(1));
        cache_req(1'b1, 32'h80, 256'h1004, lat, ok);
        shadow[4] = 256'h1004;
        check_val("fifth_acked", 256'(ok), 256'(1));
        check_val("fifth_stalled", 256'(lat > 1), 256'(1));
        check_val("fifth_after_pop", 256'(ack_cyc >= log_cyc[base] + 3), 256'(1));
        wait_idle("fill_idle");
        for (int i = 0; i < 5; i++) begin
            check_val("fill_ext", ext_line(i), 256'h1000 + 256'(i));
            check_val("fill_order", 256'(log_addr[base + i]), 256'(i * 32));
        end

        // Read miss waits for the in-flight drain but beats the next one.
        dram_delay = 15;
        base = log_we.size();
        wr("prio_a", 32'h100, 256'hAAAA, 1);
        wr("prio_b", 32'h120, 256'hBBBB, 1);
        rd("prio_rd", 32'h800, 0);
        wait_idle("prio_idle");
        check_val("prio_n", 256'(log_we.size() - base), 256'(3));
        check_val("prio0_we", 256'(log_we[base]), 256'(1));
        check_val("prio0_addr", 256'(log_addr[base]), 256'(32'h100));
        check_val("prio1_we", 256'(log_we[base + 1]), 256'(0));
        check_val("prio1_addr", 256'(log_addr[base + 1]), 256'(32'h800));
        check_val("prio2_we", 256'(log_we[base + 2]), 256'(1));
        check_val("prio2_addr", 256'(log_addr[base + 2]), 256'(32'h120));
        check_val("prio_ext64", cache_data_o, init_line(64));

        // Coalescing two writes to the same queued line.
        base = log_we.size();
        wr("coal_filler", 32'h140, 256'h5151, 1);
        wr("coal1", 32'h60, 256'h1, 1);
        wr("coal2", 32'h60, 256'h2, 1);
        wait_idle("coal_idle");
        cnt = 0;
        for (int i = base; i < log_we.size(); i++) if (log_we[i] && log_addr[i] == 32'h60) cnt++;
        check_val("coal_one_write", 256'(cnt), 256'(1));
        check_val("coal_ext3", ext_line(3), 256'h2);

        // Randomized traffic over a handful of lines; reads must see the latest write.
        for (int n = 0; n < 80; n++) begin
            dram_delay = $urandom_range(0, 8);
            a = {19'd0, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 4'd0} >> 4;
            a = {23'd0, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31))};
            if ($urandom_range(0, 1) == 1) begin
                d = rand_line();
                wr("rnd_wr", a, d, 0);
            end else begin
                rd("rnd_rd", a, 0);
            end
        end
        wait_idle("rnd_idle");
        for (int i = 0; i < 16; i++) check_val("rnd_ext", ext_line(i), shadow[i]);

        // Reset in the middle of a drain discards everything queued.
        dram_delay = 30;
        wr("mid_a", 32'h1A0, 256'hDEAD, 1);
        wr("mid_b", 32'h1C0, 256'hBEEF, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("mid_rst_cs", 256'(mem_cs_o), 256'(0));
        check_val("mid_rst_empty", 256'(empty_o), 256'(1));
        check_val("mid_rst_full", 256'(full_o), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        base = log_we.size();
        repeat (40) @(posedge clk);
        #1;
        check_val("mid_no_drain", 256'(log_we.size()), 256'(base));
        check_val("mid_cs_idle", 256'(mem_cs_o), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
